// File: rtl/lcd_frame_sequencer.sv
// HD44780 frame sequencer: power-on wait, init command list, then redraws dirty
// lines of a 2x16 character buffer through lcd_controller one byte at a time.
module lcd_frame_sequencer #(
  parameter int DELAY_SHORT = 2000,
  parameter int DELAY_LONG  = 205000,
  parameter int DELAY_PWR   = 750000,
  parameter int CNT_W       = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       refresh,
  output logic       ready,
  output logic       busy,
  output logic       start,
  output logic       RS,
  output logic [7:0] data,
  input  logic       done
);

  typedef enum logic [2:0] {
    PWR_WAIT, INIT, IDLE, LINE_ADDR, LINE_CHAR, ISSUE, WAIT_DONE, DELAY
  } state_t;

  state_t                  state, state_n, ret, ret_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic [1:0]              init_idx, init_idx_n;
  logic                    line, line_n;
  logic [3:0]              col, col_n;
  logic                    rdy, rdy_n;
  logic [1:0]              dirty, dirty_n;
  logic                    rs_q, rs_n;
  logic [7:0]              data_q, data_n;
  logic [1:0][15:0][7:0]   fb;
  logic                    cmd_rs;
  logic [7:0]              cmd_byte;
  logic                    dirty_clr;

  // Byte for the pending transaction, chosen by the phase that requested it.
  always_comb begin
    cmd_rs   = 1'b0;
    cmd_byte = 8'h00;
    case (ret)
      INIT: begin
        case (init_idx)
          2'd0:    cmd_byte = 8'h38;
          2'd1:    cmd_byte = 8'h0C;
          2'd2:    cmd_byte = 8'h06;
          default: cmd_byte = 8'h01;
        endcase
      end
      LINE_ADDR: cmd_byte = line ? 8'hC0 : 8'h80;
      LINE_CHAR: begin
        cmd_rs   = 1'b1;
        cmd_byte = fb[line][col];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n    = state;
    ret_n      = ret;
    cnt_n      = cnt;
    init_idx_n = init_idx;
    line_n     = line;
    col_n      = col;
    rdy_n      = rdy;
    rs_n       = rs_q;
    data_n     = data_q;
    case (state)
      PWR_WAIT: begin
        if (cnt == '0) begin
          state_n    = INIT;
          init_idx_n = 2'd0;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      INIT: begin
        ret_n   = INIT;
        state_n = ISSUE;
      end
      IDLE: begin
        if (dirty[0]) begin
          line_n  = 1'b0;
          state_n = LINE_ADDR;
        end else if (dirty[1]) begin
          line_n  = 1'b1;
          state_n = LINE_ADDR;
        end
      end
      LINE_ADDR: begin
        ret_n   = LINE_ADDR;
        state_n = ISSUE;
      end
      LINE_CHAR: begin
        ret_n   = LINE_CHAR;
        state_n = ISSUE;
      end
      ISSUE: begin
        rs_n    = cmd_rs;
        data_n  = cmd_byte;
        state_n = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done) begin
          state_n = DELAY;
          cnt_n   = (ret == INIT) ? CNT_W'(DELAY_LONG) : CNT_W'(DELAY_SHORT);
        end
      end
      DELAY: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          case (ret)
            INIT: begin
              if (init_idx == 2'd3) begin
                rdy_n   = 1'b1;
                state_n = IDLE;
              end else begin
                init_idx_n = init_idx + 2'd1;
                state_n    = INIT;
              end
            end
            LINE_ADDR: begin
              col_n   = 4'd0;
              state_n = LINE_CHAR;
            end
            LINE_CHAR: begin
              if (col == 4'd15) begin
                state_n = IDLE;
              end else begin
                col_n   = col + 4'd1;
                state_n = LINE_CHAR;
              end
            end
            default: state_n = IDLE;
          endcase
        end
      end
      default: state_n = PWR_WAIT;
    endcase
  end

  // Later setters win: a write or refresh landing on the clear keeps the line dirty.
  assign dirty_clr = (state == ISSUE) && (ret == LINE_ADDR);

  always_comb begin
    dirty_n = dirty;
    if (dirty_clr) dirty_n[line] = 1'b0;
    if (wr_en)     dirty_n[wr_addr[4]] = 1'b1;
    if (refresh)   dirty_n = 2'b11;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= PWR_WAIT;
      ret      <= IDLE;
      cnt      <= CNT_W'(DELAY_PWR);
      init_idx <= 2'd0;
      line     <= 1'b0;
      col      <= 4'd0;
      rdy      <= 1'b0;
      dirty    <= 2'b11;
      rs_q     <= 1'b0;
      data_q   <= 8'h00;
      fb       <= {32{8'h20}};
    end else begin
      state    <= state_n;
      ret      <= ret_n;
      cnt      <= cnt_n;
      init_idx <= init_idx_n;
      line     <= line_n;
      col      <= col_n;
      rdy      <= rdy_n;
      dirty    <= dirty_n;
      rs_q     <= rs_n;
      data_q   <= data_n;
      if (wr_en) fb[wr_addr[4]][wr_addr[3:0]] <= wr_data;
    end
  end

  // RS/data come straight from the source during ISSUE, then from the latch.
  assign start = (state == ISSUE);
  assign RS    = start ? cmd_rs : rs_q;
  assign data  = start ? cmd_byte : data_q;
  assign ready = rdy;
  assign busy  = !((state == IDLE) && (dirty == 2'b00));

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// Directed bench for lcd_frame_sequencer: models lcd_controller's done pulse,
// logs every start, and compares redraws against a shadow of the frame buffer.
module tb_lcd_frame_sequencer;
  localparam int DS = 3, DL = 5, DP = 10;

  typedef struct {
    logic       rs;
    logic [7:0] d;
    logic       rdy;
    int         cyc;
    int         gap;
  } txn_t;

  // k: 0 none, 1 write, 2 refresh; pl[i] = line expected for pass i
  typedef struct {
    int         k0;
    logic [4:0] a0;
    logic [7:0] d0;
    int         off1;
    int         k1;
    logic [4:0] a1;
    logic [7:0] d1;
    int         np;
    logic [2:0] pl;
  } vec_t;

  logic clk = 1'b0, reset = 1'b1, wr_en = 1'b0, refresh = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic ready, busy, start, RS, done;
  logic [7:0] data;
  logic resp_done = 1'b0, stray_done = 1'b0;
  assign done = resp_done | stray_done;

  lcd_frame_sequencer #(.DELAY_SHORT(DS), .DELAY_LONG(DL), .DELAY_PWR(DP), .CNT_W(20)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .refresh(refresh), .ready(ready), .busy(busy), .start(start), .RS(RS),
    .data(data), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_vec = 0, n_bad = 0, last_done = 0;
  bit   hold_chk = 1'b1;
  txn_t q[$];
  logic [1:0][15:0][7:0] shadow;
  logic       r_h;
  logic [7:0] d_h;
  vec_t       vt[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: log each start pulse with its cycle and distance from the last done.
  always @(negedge clk) begin
    txn_t t;
    if (start) begin
      t.rs = RS; t.d = data; t.rdy = ready; t.cyc = cyc; t.gap = cyc - last_done;
      q.push_back(t);
    end
  end

  // Controller model: done two cycles after the WAIT_DONE entry; checks RS/data hold.
  initial begin
    forever begin
      @(negedge clk);
      if (start) begin
        r_h = RS; d_h = data;
        @(posedge clk); @(posedge clk); #1 resp_done = 1'b1; last_done = cyc;
        @(negedge clk);
        if (hold_chk) begin chk("hold_rs_done", RS, r_h); chk("hold_data_done", data, d_h); end
        @(posedge clk); #1 resp_done = 1'b0;
        @(negedge clk);
        if (hold_chk) begin chk("hold_rs_after", RS, r_h); chk("hold_data_after", data, d_h); end
      end
    end
  end

  function automatic logic [7:0] init_cmd(input int i);
    case (i)
      0: return 8'h38;
      1: return 8'h0C;
      2: return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

  task automatic wait_q(input int n);
    int t = 0;
    while (q.size() < n && t < 1000) begin @(negedge clk); t++; end
    if (q.size() < n) begin
      n_vec++; n_bad++;
      $display("FAIL start_timeout: got %0d transactions, expected %0d", q.size(), n);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (busy !== 1'b0 && t < 1000) begin @(negedge clk); t++; end
    chk("busy_idle", busy, 0);
  endtask

  task automatic check_line(input logic ln, input logic [15:0][7:0] exp, output txn_t first);
    txn_t e;
    first = '{1'bx, 8'hxx, 1'bx, -1000, 0};
    wait_q(17);
    if (q.size() < 17) return;
    e = q.pop_front(); first = e;
    chk("addr_rs", e.rs, 0);
    chk("addr_data", e.d, ln ? 8'hC0 : 8'h80);
    for (int c = 0; c < 16; c++) begin
      e = q.pop_front();
      chk("char_rs", e.rs, 1);
      chk($sformatf("char_l%0d_c%0d", ln, c), e.d, exp[c]);
    end
  endtask

  task automatic check_init(input int r);
    txn_t e;
    for (int i = 0; i < 4; i++) begin
      wait_q(1);
      if (q.size() < 1) return;
      e = q.pop_front();
      if (i == 0) chk("pwr_wait_gap_gt10", (e.cyc - r) > 10, 1);
      else        chk("init_gap_ge_long", e.gap >= DL, 1);
      chk("init_rs", e.rs, 0);
      chk($sformatf("init_cmd%0d", i), e.d, init_cmd(i));
      chk("init_ready_low", e.rdy, 0);
    end
    check_line(1'b0, shadow[0], e);
    chk("ready_after_init", e.rdy, 1);
    check_line(1'b1, shadow[1], e);
  endtask

  task automatic drive_ev(input int k, input logic [4:0] a, input logic [7:0] d);
    if (k == 1) begin
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      shadow[a[4]][a[3:0]] = d;
    end else if (k == 2) begin
      refresh = 1'b1;
    end
  endtask

  task automatic clr_ev();
    wr_en = 1'b0; refresh = 1'b0;
  endtask

  task automatic do_reset(output int r);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); @(posedge clk); #1 r = cyc;
    shadow = {32{8'h20}};
    chk("rst_start", start, 0);
    chk("rst_rs", RS, 0);
    chk("rst_data", data, 8'h00);
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 1);
    reset = 1'b0;
  endtask

  initial begin
    int r0, n0;
    txn_t t;
    logic [15:0][7:0] snap;

    vt[0]  = '{1, 5'h13, 8'h41, 0, 0, 5'h00, 8'h00, 1, 3'b001};
    vt[1]  = '{1, 5'h00, 8'h48, 1, 1, 5'h10, 8'h69, 2, 3'b010};
    vt[2]  = '{1, 5'h10, 8'h78, 1, 1, 5'h00, 8'h79, 2, 3'b001};
    vt[3]  = '{1, 5'h02, 8'h70, 1, 1, 5'h07, 8'h71, 1, 3'b000};
    vt[4]  = '{1, 5'h0F, 8'h21, 0, 0, 5'h00, 8'h00, 1, 3'b000};
    vt[5]  = '{1, 5'h1F, 8'h7E, 0, 0, 5'h00, 8'h00, 1, 3'b001};
    vt[6]  = '{2, 5'h00, 8'h00, 0, 0, 5'h00, 8'h00, 2, 3'b010};
    vt[7]  = '{1, 5'h11, 8'h72, 10, 2, 5'h00, 8'h00, 3, 3'b101};
    vt[8]  = '{1, 5'h00, 8'h63, 3, 2, 5'h00, 8'h00, 3, 3'b100};
    vt[9]  = '{1, 5'h03, 8'h64, 3, 1, 5'h04, 8'h65, 2, 3'b000};
    vt[10] = '{1, 5'h1A, 8'h7F, 3, 1, 5'h00, 8'h66, 2, 3'b001};

    shadow = {32{8'h20}};
    repeat (3) @(posedge clk);
    #1 r0 = cyc;
    chk("rst_start", start, 0);
    chk("rst_rs", RS, 0);
    chk("rst_data", data, 8'h00);
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 1);
    reset = 1'b0;
    check_init(r0);
    wait_idle();
    chk("no_extra_after_init", q.size(), 0);

    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1 drive_ev(vt[i].k0, vt[i].a0, vt[i].d0);
      @(posedge clk); #1 n0 = cyc; clr_ev();
      for (int k = 1; k <= vt[i].off1; k++) begin
        if (k == vt[i].off1) drive_ev(vt[i].k1, vt[i].a1, vt[i].d1);
        @(posedge clk); #1 clr_ev();
      end
      for (int p = 0; p < vt[i].np; p++) begin
        check_line(vt[i].pl[p], shadow[vt[i].pl[p]], t);
        if (p == 0) chk($sformatf("v%0d_latency", i), t.cyc - n0, 2);
      end
      wait_idle();
      chk($sformatf("v%0d_no_extra", i), q.size(), 0);
    end

    // Writes landing mid-pass: column 5 already sent, column 14 not yet.
    @(posedge clk); #1 drive_ev(1, 5'h00, 8'h6D);
    @(posedge clk); #1 clr_ev();
    snap = shadow[0];
    wait_q(12);
    @(posedge clk); #1 drive_ev(1, 5'h05, 8'h5A);
    @(posedge clk); #1 drive_ev(1, 5'h0E, 8'h59);
    @(posedge clk); #1 clr_ev();
    snap[14] = 8'h59;
    check_line(1'b0, snap, t);
    check_line(1'b0, shadow[0], t);
    wait_idle();
    chk("midpass_no_extra", q.size(), 0);

    // Stray done while idle.
    @(posedge clk); #1 stray_done = 1'b1;
    @(posedge clk); #1 stray_done = 1'b0;
    repeat (6) @(posedge clk);
    #1 chk("stray_busy", busy, 0);
    chk("stray_no_start", q.size(), 0);

    // Reset while waiting on done for a character.
    hold_chk = 1'b0;
    @(posedge clk); #1 refresh = 1'b1;
    @(posedge clk); #1 refresh = 1'b0;
    wait_q(5);
    do_reset(r0);
    q.delete();
    repeat (5) @(posedge clk);
    hold_chk = 1'b1;
    check_init(r0);
    wait_idle();
    chk("reinit_no_extra", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
